uart_rx_string: RTL
===================

UART_RX_STRING -- requirements
Module: uart_rx_string

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz used for baud divider computation.
REQ-002 SHALL have port Clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Rs232_Rx  input  1  serial line, idle high, asynchronous to Clk.
REQ-005 SHALL have port baud_set  input  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=9600.
REQ-006 SHALL have port data_byte  output  8  last correctly framed received byte.
REQ-007 SHALL have port Rx_Done  output  1  one-cycle pulse, new byte valid on data_byte.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port match  output  1  one-cycle pulse, string "HELLO\n" (0x48 45 4C 4C 4F 0A) fully received.
REQ-010 SHALL have port led  output  1  toggles on every match.
REQ-011 SHALL have port uart_state  output  1  high whenever receiver FSM is not IDLE.

Function
REQ-012 SHALL pass Rs232_Rx through a 2-flop synchronizer, then a 1-flop delay for edge detection.
REQ-013 SHALL derive bit period BP = CLK_FREQ/baud (integer, e.g. 5208/2604/1302/868/434 at 50 MHz); baud_set latched at start-edge detection and held for the frame.
REQ-014 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE -> START on synchronized falling edge; bit counter cleared.
REQ-016 START: after BP/2 cycles sample line; 0 -> DATA, 1 -> IDLE (glitch rejected, no output pulses).
REQ-017 DATA: every BP cycles sample one bit, LSB first, into shift register; after 8th bit -> STOP.
REQ-018 STOP: after BP cycles sample line; 1 -> load data_byte, pulse Rx_Done next cycle, -> IDLE; 0 -> pulse frame_err, data_byte unchanged, -> WAIT_HIGH.
REQ-019 WAIT_HIGH -> IDLE once synchronized line is 1; no start detection in WAIT_HIGH.
REQ-020 data_byte SHALL hold its value until the next good frame.
REQ-021 Matcher index idx 0..5; on Rx_Done: byte == expected[idx] -> idx+1; else byte == 0x48 -> idx=1; else idx=0.
REQ-022 Byte 0x0A at idx=5 SHALL pulse match the cycle after Rx_Done, toggle led same cycle, reset idx to 0.
REQ-023 frame_err SHALL reset idx to 0.
REQ-024 Back-to-back frames (stop bit directly followed by start bit) SHALL be received without loss.
REQ-025 Rx_Done and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-026 On Rst_n low, asynchronously: FSM=IDLE, data_byte=0x00, Rx_Done=0, frame_err=0, match=0, led=0, uart_state=0, idx=0, synchronizer flops=1, counters=0.
REQ-027 Reset mid-frame SHALL abandon the frame with no Rx_Done or frame_err pulse; reception resumes at the next falling edge after release.

Verification
REQ-028 baud_set=4, send 0x55 with valid stop -> exactly one Rx_Done, data_byte=0x55, ~10*434 cycles after start edge.
REQ-029 baud_set=0, send "HELLO\n" back-to-back -> six Rx_Done pulses, one match pulse after the 0x0A byte, led 0->1.
REQ-030 Send "HEHELLO\n" -> one match, led toggles once; send "HELXO\n" -> no match.
REQ-031 Send 0xA3 with stop bit low -> frame_err pulse, no Rx_Done, data_byte unchanged, uart_state high until line returns high.
REQ-032 Low pulse of BP/4 on idle line -> no Rx_Done, no frame_err, uart_state returns to 0 after BP/2 cycles.
REQ-033 Assert Rst_n low during DATA of third byte of "HELLO\n", release, resend full string -> all outputs reset immediately, then one match.

Source files
------------

// File: rtl/uart_rx_string_if.sv
// uart_rx_string_if: serial input, rate select and receive/match outputs of the string receiver
interface uart_rx_string_if;
   logic       Rs232_Rx;
   logic [2:0] baud_set;
   logic [7:0] data_byte;
   logic       Rx_Done;
   logic       frame_err;
   logic       match;
   logic       led;
   logic       uart_state;
   modport master (output Rs232_Rx, baud_set, input data_byte, Rx_Done, frame_err, match, led, uart_state);
   modport slave  (input Rs232_Rx, baud_set, output data_byte, Rx_Done, frame_err, match, led, uart_state);
endinterface

// File: rtl/uart_rx_string.sv
// uart_rx_string: 8N1 UART receiver with selectable baud that flags reception of "HELLO\n"
module uart_rx_string #(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic            Clk,
   input  logic            Rst_n,
   uart_rx_string_if.slave u
);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
   localparam logic [31:0] BP0 = 32'(CLK_FREQ / 9600);
   localparam logic [31:0] BP1 = 32'(CLK_FREQ / 19200);
   localparam logic [31:0] BP2 = 32'(CLK_FREQ / 38400);
   localparam logic [31:0] BP3 = 32'(CLK_FREQ / 57600);
   localparam logic [31:0] BP4 = 32'(CLK_FREQ / 115200);
   localparam logic [47:0] STR = 48'h48_45_4C_4C_4F_0A;
   state_t      state_q, state_d;
   logic [2:0]  sync_q, sync_d;
   logic [2:0]  baud_q, baud_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        done_q, done_d;
   logic        ferr_q, ferr_d;
   logic        match_q, match_d;
   logic        led_q, led_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] bp;
   logic [47:0] str_sh;
   logic        rx, fall, tick, hit;
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         sync_q  <= 3'b111;
         baud_q  <= 3'd0;
         cnt_q   <= 32'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         match_q <= 1'b0;
         led_q   <= 1'b0;
         idx_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         baud_q  <= baud_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         match_q <= match_d;
         led_q   <= led_d;
         idx_q   <= idx_d;
      end
   end
   // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect delay
   always_comb begin
      sync_d = {sync_q[1:0], u.Rs232_Rx};
      rx     = sync_q[1];
      fall   = sync_q[2] & ~sync_q[1];
      bp     = baud_q == 3'd1 ? BP1 : baud_q == 3'd2 ? BP2 : baud_q == 3'd3 ? BP3 : baud_q == 3'd4 ? BP4 : BP0;
      tick   = cnt_q == (state_q == START ? bp >> 1 : bp) - 32'd1;
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 32'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      baud_d  = baud_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = 32'd0;
            if (fall) begin
               state_d = START;
               bit_d   = 3'd0;
               baud_d  = u.baud_set;
            end
         end
         START: if (tick) begin
            cnt_d   = 32'd0;
            state_d = rx ? IDLE : DATA;
         end
         DATA: if (tick) begin
            cnt_d   = 32'd0;
            shift_d = {rx, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            state_d = bit_q == 3'd7 ? STOP : DATA;
         end
         STOP: if (tick) begin
            cnt_d   = 32'd0;
            state_d = rx ? IDLE : WAIT_HIGH;
            data_d  = rx ? shift_q : data_q;
            done_d  = rx;
            ferr_d  = ~rx;
         end
         WAIT_HIGH: begin
            cnt_d   = 32'd0;
            state_d = rx ? IDLE : WAIT_HIGH;
         end
         default: state_d = IDLE;
      endcase
   end
   // matcher advances on each completed byte; a stray 'H' restarts at index 1
   always_comb begin
      str_sh  = STR << {idx_q, 3'b000};
      hit     = data_q == str_sh[47:40];
      match_d = done_q & hit & (idx_q == 3'd5);
      led_d   = led_q ^ match_d;
      idx_d   = ferr_q ? 3'd0 : !done_q ? idx_q : hit ? (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1) : data_q == 8'h48 ? 3'd1 : 3'd0;
   end
   assign u.data_byte  = data_q;
   assign u.Rx_Done    = done_q;
   assign u.frame_err  = ferr_q;
   assign u.match      = match_q;
   assign u.led        = led_q;
   assign u.uart_state = state_q != IDLE;
endmodule
